// File: rtl/weight_mem_pkg.sv
// Shared definitions for the double-buffered shadow weight memory and its
// commit controller: state encodings, bank geometry defaults, bank walk helper.
package weight_mem_pkg;

   localparam int DEF_NUM_BANKS = 3;
   localparam int DEF_BANK_SIZE = 1170;

   // Bank masks are widened to this width before searching; a 2-bit bank
   // index can never address more than four banks.
   localparam int         MASK_W  = 4;
   localparam logic [2:0] NO_BANK = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WRITE   = 3'd1,
      ST_REQ     = 3'd2,
      ST_RELEASE = 3'd3,
      ST_ERROR   = 3'd4
   } wc_state_t;

   // Lowest set bank index at or above 'after'; NO_BANK when none is left.
   function automatic logic [2:0] next_bank(input logic [MASK_W-1:0] mask,
                                            input logic [2:0]        after);
      logic [2:0] found;
      found = NO_BANK;
      for (int i = MASK_W - 1; i >= 0; i--) begin
         if (mask[i] && (i >= int'(after))) found = 3'(i);
      end
      return found;
   endfunction

endpackage

// File: rtl/handshake_timer.sv
// Loadable down-counter bounding each phase of the swap handshake.
// expired is high once the counter has run down to zero and stays there
// until the next load.
module handshake_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             expired
);

   logic [WIDTH-1:0] cnt;

   // Reload on phase entry, otherwise count down and hold at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             cnt <= '0;
      else if (load)          cnt <= load_val;
      else if (cnt != '0)     cnt <= cnt - 1'b1;
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/weight_commit_ctrl.sv
// Commit sequencer for the shadow weight memory: streams each selected bank
// into the inactive buffer, then runs the four-phase swap handshake
// (swap_req up, swap_ack up, swap_req down, swap_ack down). Banks written by
// a commit are stale in the buffer that becomes inactive after the swap, so
// they are folded into the next commit to keep both buffers converged.
//
// Word stream: a word transfers on every clk_wr edge where w_valid and
// w_ready are both high; w_valid may toggle freely, w_ready is high only
// while a bank is being streamed, and abort in the same cycle drops the word.
module weight_commit_ctrl
   import weight_mem_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 16,
   parameter int BANK_SIZE   = DEF_BANK_SIZE,
   parameter int NUM_BANKS   = DEF_NUM_BANKS,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                  clk_wr,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [NUM_BANKS-1:0]  bank_mask,
   input  logic                  abort,
   input  logic                  err_clr,
   input  logic                  w_valid,
   input  logic [DATA_WIDTH-1:0] w_data,
   output logic                  w_ready,
   output logic [1:0]            cur_bank,
   output logic [NUM_BANKS-1:0]  eff_mask,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   output logic [1:0]            mem_wr_bank_sel,
   output logic                  swap_req,
   input  logic                  swap_ack,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [15:0]           commit_cnt,
   output logic [2:0]            state_dbg
);

   localparam int                    TW         = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0]         TIMER_LOAD = TW'(ACK_TIMEOUT - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(BANK_SIZE - 1);
   localparam logic [NUM_BANKS-1:0]  ALL_BANKS  = '1;

   wc_state_t             state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [NUM_BANKS-1:0]  stale_mask;
   logic [NUM_BANKS-1:0]  start_mask;
   logic [MASK_W-1:0]     start_ext;
   logic [MASK_W-1:0]     eff_ext;
   logic [2:0]            first_bank;
   logic [2:0]            following_bank;
   logic                  flush;
   logic                  timer_load;
   logic                  timer_expired;

   assign start_mask = bank_mask | stale_mask;
   assign state_dbg  = state;

   // Widen bank masks to the search width used by the bank walk helper.
   always_comb begin
      start_ext                  = '0;
      eff_ext                    = '0;
      start_ext[NUM_BANKS-1:0]   = start_mask;
      eff_ext[NUM_BANKS-1:0]     = eff_mask;
   end

   assign first_bank     = next_bank(start_ext, 3'd0);
   assign following_bank = next_bank(eff_ext, {1'b0, cur_bank} + 3'd1);

   // Each handshake phase gets a fresh budget when it is entered.
   assign timer_load = ((state == ST_WRITE) && flush && !abort) ||
                       ((state == ST_REQ) && swap_ack);

   handshake_timer #(.WIDTH(TW)) u_timer (
      .clk      (clk_wr),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (TIMER_LOAD),
      .expired  (timer_expired)
   );

   // Commit sequencer with all outputs registered alongside the state.
   always_ff @(posedge clk_wr or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         addr            <= '0;
         stale_mask      <= '0;
         flush           <= 1'b0;
         w_ready         <= 1'b0;
         cur_bank        <= '0;
         eff_mask        <= '0;
         mem_wr_en       <= 1'b0;
         mem_wr_addr     <= '0;
         mem_wr_data     <= '0;
         mem_wr_bank_sel <= '0;
         swap_req        <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
         commit_cnt      <= '0;
      end else begin
         done      <= 1'b0;
         mem_wr_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  eff_mask <= start_mask;
                  if (first_bank == NO_BANK) begin
                     // Nothing to write and nothing stale: report completion.
                     done <= 1'b1;
                  end else begin
                     state    <= ST_WRITE;
                     cur_bank <= first_bank[1:0];
                     addr     <= '0;
                     flush    <= 1'b0;
                     w_ready  <= 1'b1;
                     busy     <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (abort) begin
                  stale_mask <= eff_mask;
                  state      <= ST_IDLE;
                  w_ready    <= 1'b0;
                  busy       <= 1'b0;
                  flush      <= 1'b0;
               end else if (flush) begin
                  // One idle cycle so the last write lands before the request.
                  flush    <= 1'b0;
                  state    <= ST_REQ;
                  swap_req <= 1'b1;
               end else if (w_valid) begin
                  mem_wr_en       <= 1'b1;
                  mem_wr_addr     <= addr;
                  mem_wr_data     <= w_data;
                  mem_wr_bank_sel <= cur_bank;
                  if (addr == LAST_ADDR) begin
                     addr <= '0;
                     if (following_bank == NO_BANK) begin
                        flush   <= 1'b1;
                        w_ready <= 1'b0;
                     end else begin
                        cur_bank <= following_bank[1:0];
                     end
                  end else begin
                     addr <= addr + 1'b1;
                  end
               end
            end
            ST_REQ: begin
               if (swap_ack) begin
                  state    <= ST_RELEASE;
                  swap_req <= 1'b0;
               end else if (timer_expired) begin
                  state      <= ST_ERROR;
                  swap_req   <= 1'b0;
                  err        <= 1'b1;
                  stale_mask <= ALL_BANKS;
               end
            end
            ST_RELEASE: begin
               if (!swap_ack) begin
                  stale_mask <= eff_mask;
                  commit_cnt <= commit_cnt + 16'd1;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  state      <= ST_IDLE;
               end else if (timer_expired) begin
                  state      <= ST_ERROR;
                  err        <= 1'b1;
                  stale_mask <= ALL_BANKS;
               end
            end
            ST_ERROR: begin
               // Swap outcome unknown: both buffers must be fully rewritten.
               stale_mask <= ALL_BANKS;
               if (err_clr) begin
                  state <= ST_IDLE;
                  err   <= 1'b0;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weight_commit_ctrl.sv
// Bench for weight_commit_ctrl: randomized word streams against a queue of
// expected memory writes, a swap_ack responder, and per-cycle output checks.
module tb_weight_commit_ctrl;

   localparam int DW = 16;
   localparam int AW = 16;
   localparam int BS = 1170;
   localparam int NB = 3;

   logic          clk_wr = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [NB-1:0] bank_mask = '0;
   logic          abort = 1'b0;
   logic          err_clr = 1'b0;
   logic          w_valid = 1'b0;
   logic [DW-1:0] w_data = '0;
   logic          swap_ack = 1'b0;
   logic          w_ready;
   logic [1:0]    cur_bank;
   logic [NB-1:0] eff_mask;
   logic          mem_wr_en;
   logic [AW-1:0] mem_wr_addr;
   logic [DW-1:0] mem_wr_data;
   logic [1:0]    mem_wr_bank_sel;
   logic          swap_req;
   logic          busy;
   logic          done;
   logic          err;
   logic [15:0]   commit_cnt;
   logic [2:0]    state_dbg;

   always #5 clk_wr = ~clk_wr;

   weight_commit_ctrl dut (
      .clk_wr          (clk_wr),
      .rst_n           (rst_n),
      .start           (start),
      .bank_mask       (bank_mask),
      .abort           (abort),
      .err_clr         (err_clr),
      .w_valid         (w_valid),
      .w_data          (w_data),
      .w_ready         (w_ready),
      .cur_bank        (cur_bank),
      .eff_mask        (eff_mask),
      .mem_wr_en       (mem_wr_en),
      .mem_wr_addr     (mem_wr_addr),
      .mem_wr_data     (mem_wr_data),
      .mem_wr_bank_sel (mem_wr_bank_sel),
      .swap_req        (swap_req),
      .swap_ack        (swap_ack),
      .busy            (busy),
      .done            (done),
      .err             (err),
      .commit_cnt      (commit_cnt),
      .state_dbg       (state_dbg)
   );

   int          total = 0;
   int          bad = 0;
   logic [33:0] exp_q[$];
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          req_rises = 0;
   int          req_run = 0;
   int          last_req_run = 0;
   int          cyc = 0;
   int          last_wr_cyc = -10;
   int          exp_cnt = 0;
   logic        ack_en = 1'b1;
   logic [2:0]  hist = '0;
   logic        ack_fell = 1'b0;
   logic        prev_req = 1'b0;
   logic [2:0]  model_stale = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {busy, done, err, swap_req, w_ready, mem_wr_en, mem_wr_addr, mem_wr_data,
              mem_wr_bank_sel, cur_bank, eff_mask, commit_cnt, state_dbg};
   endfunction

   // Monitor and swap_ack responder: checks outputs on every falling edge,
   // then drives swap_ack as swap_req delayed by three cycles.
   initial begin
      logic [33:0] e;
      logic        new_ack;
      forever begin
         @(negedge clk_wr);
         cyc++;
         if (!rst_n) begin
            hist     = '0;
            swap_ack = 1'b0;
            ack_fell = 1'b0;
            prev_req = 1'b0;
            req_run  = 0;
            exp_cnt  = 0;
         end else begin
            if (mem_wr_en) begin
               wr_cnt++;
               last_wr_cyc = cyc;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL wr_unexpected: got bank=%0d addr=%0d data=%h expected no write",
                           mem_wr_bank_sel, mem_wr_addr, mem_wr_data);
               end else begin
                  e = exp_q.pop_front();
                  check("wr_word", 64'({mem_wr_bank_sel, mem_wr_addr, mem_wr_data}), 64'(e));
               end
            end
            if (swap_req && !prev_req) begin
               req_rises++;
               check("req_after_last_wr", 64'(cyc), 64'(last_wr_cyc + 1));
            end
            check("req_wr_overlap", 64'(swap_req & mem_wr_en), 64'(0));
            if (swap_req) req_run++;
            else if (prev_req) begin
               last_req_run = req_run;
               req_run = 0;
            end
            if (done) done_cnt++;
            if (ack_fell) begin
               check("done_after_ack_low", 64'(done), 64'(1));
               exp_cnt++;
            end
            check("commit_cnt", 64'(commit_cnt), 64'(exp_cnt[15:0]));
            check("flag_consistency",
                  64'({w_ready & ~busy, swap_req & ~busy, err & ~busy, done & busy}), 64'(0));
            prev_req = swap_req;
            hist     = {hist[1:0], swap_req};
            new_ack  = ack_en & hist[2];
            ack_fell = swap_ack & ~new_ack;
            swap_ack = new_ack;
         end
      end
   end

   // Drive the word stream for one commit; expected writes are derived from
   // the bank list of the commit and the order words are accepted.
   task automatic stream(input logic [2:0] eff, input int duty, input int abort_at,
                         input int start_at);
      int         banks[$];
      int         n;
      int         k;
      int         guard;
      bit         pulsed;
      logic [1:0] b;
      logic [15:0] a;
      for (int i = 0; i < NB; i++) if (eff[i]) banks.push_back(i);
      n = banks.size() * BS;
      k = 0;
      guard = 0;
      pulsed = 0;
      while (k < n && guard < 20000) begin
         @(negedge clk_wr);
         guard++;
         w_valid = (int'($urandom_range(99)) < duty);
         w_data  = DW'($urandom);
         start   = 1'b0;
         if (start_at >= 0 && k >= start_at && !pulsed) begin
            start  = 1'b1;
            pulsed = 1;
         end
         abort = (abort_at >= 0 && k == abort_at);
         if (abort) w_valid = 1'b1;
         if (w_valid && w_ready && !abort) begin
            b = 2'(banks[k / BS]);
            a = 16'(k % BS);
            exp_q.push_back({b, a, w_data});
            k++;
         end
         if (abort) break;
      end
      if (abort_at < 0) check("stream_words", 64'(k), 64'(n));
      @(negedge clk_wr);
      w_valid = 1'b0;
      abort   = 1'b0;
      start   = 1'b0;
   endtask

   task automatic do_commit(input logic [2:0] m, input int duty, input int abort_at,
                            input int start_at, output logic [2:0] eff);
      eff = m | model_stale;
      @(negedge clk_wr);
      bank_mask = m;
      start     = 1'b1;
      @(negedge clk_wr);
      start = 1'b0;
      check("eff_mask_model", 64'(eff_mask), 64'(eff));
      check("start_to_ready", 64'(w_ready), 64'(eff != 3'b000));
      if (eff != 3'b000) stream(eff, duty, abort_at, start_at);
   endtask

   task automatic wait_done(input int d0, input int limit);
      int n;
      n = 0;
      while (done_cnt == d0 && n < limit) begin
         @(negedge clk_wr);
         n++;
      end
      @(negedge clk_wr);
      check("done_once", 64'(done_cnt - d0), 64'(1));
      check("queue_drained", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic do_reset();
      @(negedge clk_wr);
      rst_n = 1'b0;
      @(negedge clk_wr);
      @(negedge clk_wr);
      check("reset_outputs", all_outs(), 64'(0));
      rst_n = 1'b1;
      model_stale = '0;
   endtask

   initial begin
      logic [2:0] eff;
      int d0;
      int w0;
      int r0;
      int n;

      do_reset();

      // Single bank, continuous stream.
      d0 = done_cnt; w0 = wr_cnt;
      do_commit(3'b001, 100, -1, -1, eff);
      check("c1_eff_literal", 64'(eff_mask), 64'(3'b001));
      wait_done(d0, 60);
      check("c1_writes", 64'(wr_cnt - w0), 64'(1170));
      check("c1_commit_cnt", 64'(commit_cnt), 64'(1));
      model_stale = eff;

      // Stale bank 0 is folded in; ~50% duty on w_valid.
      d0 = done_cnt; w0 = wr_cnt; r0 = req_rises;
      do_commit(3'b010, 50, -1, -1, eff);
      check("c2_eff_literal", 64'(eff_mask), 64'(3'b011));
      wait_done(d0, 60);
      check("c2_writes", 64'(wr_cnt - w0), 64'(2340));
      check("c2_one_swap", 64'(req_rises - r0), 64'(1));
      check("c2_commit_cnt", 64'(commit_cnt), 64'(2));
      model_stale = eff;

      // start pulsed during WRITE and during REQ is ignored.
      d0 = done_cnt; w0 = wr_cnt;
      do_commit(3'b100, 100, -1, 100, eff);
      n = 0;
      while (!swap_req && n < 20) begin
         @(negedge clk_wr);
         n++;
      end
      check("c3_req_reached", 64'(swap_req), 64'(1));
      bank_mask = 3'b001;
      start = 1'b1;
      @(negedge clk_wr);
      start = 1'b0;
      wait_done(d0, 60);
      @(negedge clk_wr);
      check("c3_no_restart", 64'(busy), 64'(0));
      check("c3_eff_literal", 64'(eff_mask), 64'(3'b111));
      check("c3_writes", 64'(wr_cnt - w0), 64'(3510));
      check("c3_commit_cnt", 64'(commit_cnt), 64'(3));
      model_stale = eff;

      // swap_ack never arrives: timeout into ERROR.
      ack_en = 1'b0;
      d0 = done_cnt;
      do_commit(3'b001, 100, -1, -1, eff);
      n = 0;
      while (!err && n < 400) begin
         @(negedge clk_wr);
         n++;
      end
      @(negedge clk_wr);
      check("to_err", 64'(err), 64'(1));
      check("to_req_cycles", 64'(last_req_run), 64'(255));
      check("to_req_low", 64'(swap_req), 64'(0));
      check("to_busy", 64'(busy), 64'(1));
      err_clr = 1'b1;
      start   = 1'b1;
      @(negedge clk_wr);
      err_clr = 1'b0;
      start   = 1'b0;
      check("clr_err", 64'(err), 64'(0));
      check("clr_idle", 64'({busy, w_ready}), 64'(0));
      check("to_no_done", 64'(done_cnt - d0), 64'(0));
      check("to_commit_cnt", 64'(commit_cnt), 64'(3));
      model_stale = 3'b111;
      ack_en = 1'b1;

      // After an error every bank is rewritten.
      d0 = done_cnt; w0 = wr_cnt;
      do_commit(3'b000, 50, -1, -1, eff);
      check("c5_eff_literal", 64'(eff_mask), 64'(3'b111));
      wait_done(d0, 60);
      check("c5_writes", 64'(wr_cnt - w0), 64'(3510));
      check("c5_commit_cnt", 64'(commit_cnt), 64'(4));
      model_stale = eff;

      // Abort after 500 words of bank 2, with a word offered in the same cycle.
      do_reset();
      d0 = done_cnt; w0 = wr_cnt; r0 = req_rises;
      do_commit(3'b100, 100, 500, -1, eff);
      repeat (10) @(negedge clk_wr);
      check("ab_writes", 64'(wr_cnt - w0), 64'(500));
      check("ab_idle", 64'(busy), 64'(0));
      check("ab_no_done", 64'(done_cnt - d0), 64'(0));
      check("ab_no_swap", 64'(req_rises - r0), 64'(0));
      check("ab_queue", 64'(exp_q.size()), 64'(0));
      model_stale = eff;

      // Aborted bank is stale; reset lands while the handshake is in RELEASE.
      w0 = wr_cnt;
      do_commit(3'b000, 100, -1, -1, eff);
      check("ab_eff_literal", 64'(eff_mask), 64'(3'b100));
      n = 0;
      while (!swap_req && n < 20) begin
         @(negedge clk_wr);
         n++;
      end
      n = 0;
      while (swap_req && n < 20) begin
         @(negedge clk_wr);
         n++;
      end
      check("rel_writes", 64'(wr_cnt - w0), 64'(1170));
      check("rel_busy", 64'({busy, swap_req}), 64'(2'b10));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", all_outs(), 64'(0));
      @(negedge clk_wr);
      @(negedge clk_wr);
      rst_n = 1'b1;
      model_stale = '0;

      // Empty commit: done pulses, no write, no swap.
      d0 = done_cnt; w0 = wr_cnt; r0 = req_rises;
      do_commit(3'b000, 100, -1, -1, eff);
      check("z_done", 64'(done), 64'(1));
      check("z_idle", 64'(busy), 64'(0));
      check("z_eff", 64'(eff_mask), 64'(0));
      @(negedge clk_wr);
      check("z_done_pulse", 64'(done), 64'(0));
      check("z_done_count", 64'(done_cnt - d0), 64'(1));
      check("z_no_write", 64'(wr_cnt - w0), 64'(0));
      check("z_no_swap", 64'(req_rises - r0), 64'(0));
      check("z_commit_cnt", 64'(commit_cnt), 64'(0));

      repeat (3) @(negedge clk_wr);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
